ps2_mouse_init_seq: RTL and testbench

- Host-side controller for the PS/2 mouse link; sits between the PS/2 byte transmitter/receiver and the cursor-position logic.
- After reset it runs the mouse initialisation command sequence with ACK checking, resend handling, timeouts and bounded retries.
- It then switches to stream mode and frames incoming bytes into aligned movement packets with 9-bit signed dx/dy.
- Downstream cursor logic consumes only pkt_valid packets.

---
 rtl/ps2_mouse_init_seq.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_ps2_mouse_init_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_init_seq.sv
// PS/2 mouse host controller: runs the init command sequence, then frames stream-mode packets.
// Build option: define WHEEL_DETECT_EN to probe for a wheel mouse and accept 4-byte packets.
module ps2_mouse_init_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES     = 100000,
  parameter logic [7:0]  SAMPLE_RATE    = 8'd100,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_ack,
  input  logic       tx_err,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       init_done,
  output logic       init_error,
  output logic       pkt_valid,
  output logic [2:0] pkt_buttons,
  output logic [8:0] pkt_dx,
  output logic [8:0] pkt_dy,
  output logic [1:0] pkt_ovf,
  output logic [3:0] pkt_dz,
  output logic       wheel_present,
  output logic       sync_error
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
`ifdef WHEEL_DETECT_EN
  localparam logic [3:0] LAST_STEP = 4'd10;
  localparam logic [3:0] ID_STEP   = 4'd9;
`else
  localparam logic [3:0] LAST_STEP = 4'd3;
`endif

  typedef enum logic [2:0] {SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, WAIT_ID, STREAM, ERROR} state_t;

  state_t        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [7:0]    retry_q, retry_d;
  logic [1:0]    resend_q, resend_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tx_req_q, tx_req_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          fail, timed_out;
  logic [1:0]    idx_q, idx_d, last_idx;
  logic [GW-1:0] gap_q, gap_d;
  logic [6:0]    hdr_q, hdr_d;
  logic [7:0]    b1_q, b1_d;
  logic          pkt_valid_q, pkt_valid_d, sync_q, sync_d;
  logic [2:0]    buttons_q, buttons_d;
  logic [8:0]    dx_q, dx_d, dy_q, dy_d;
  logic [1:0]    ovf_q, ovf_d;
`ifdef WHEEL_DETECT_EN
  logic          wheel_q, wheel_d;
  logic [7:0]    b2_q, b2_d;
  logic [3:0]    dz_q, dz_d;
`endif

  function automatic logic [7:0] cmd_at(input logic [3:0] s);
    case (s)
      4'd0:    cmd_at = 8'hFF;
      4'd1:    cmd_at = 8'hF3;
      4'd2:    cmd_at = SAMPLE_RATE;
`ifdef WHEEL_DETECT_EN
      4'd3, 4'd5, 4'd7: cmd_at = 8'hF3;
      4'd4:    cmd_at = 8'hC8;
      4'd6:    cmd_at = 8'h64;
      4'd8:    cmd_at = 8'h50;
      4'd9:    cmd_at = 8'hF2;
`endif
      default: cmd_at = 8'hF4;
    endcase
  endfunction

  assign timed_out = (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    retry_d   = retry_q;
    resend_d  = resend_q;
    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    fail      = 1'b0;
`ifdef WHEEL_DETECT_EN
    wheel_d   = wheel_q;
`endif
    case (state_q)
      SEND: begin
        tx_data_d = cmd_at(step_q);
        tx_req_d  = 1'b1;
        state_d   = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_ack) begin
          tx_req_d = 1'b0;
          state_d  = WAIT_ACK;
        end else if (tx_err || timed_out) begin
          tx_req_d = 1'b0;
          fail     = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (rx_valid) begin
          if (rx_data == 8'hFA) begin
            resend_d = 2'd0;
            if (step_q == 4'd0) state_d = WAIT_BAT;
`ifdef WHEEL_DETECT_EN
            else if (step_q == ID_STEP) state_d = WAIT_ID;
`endif
            else if (step_q == LAST_STEP) state_d = STREAM;
            else begin
              step_d  = step_q + 4'd1;
              state_d = SEND;
            end
          end else if (rx_data == 8'hFE && resend_q != 2'd2) begin
            resend_d = resend_q + 2'd1;
            state_d  = SEND;
          end else begin
            fail = 1'b1;
          end
        end else if (timed_out) begin
          fail = 1'b1;
        end
      end
      WAIT_BAT: begin
        if (rx_valid) begin
          if (rx_data == 8'hAA) state_d = WAIT_ID;
          else fail = 1'b1;
        end else if (timed_out) begin
          fail = 1'b1;
        end
      end
      WAIT_ID: begin
        if (rx_valid) begin
`ifdef WHEEL_DETECT_EN
          // Device ID after F2: only 0x03 means the wheel protocol was unlocked.
          if (step_q == ID_STEP) begin
            wheel_d = (rx_data == 8'h03);
            step_d  = step_q + 4'd1;
            state_d = SEND;
          end else
`endif
          if (rx_data == 8'h00) begin
            step_d  = 4'd1;
            state_d = SEND;
          end else begin
            fail = 1'b1;
          end
        end else if (timed_out) begin
          fail = 1'b1;
        end
      end
      default: ;
    endcase
    if (fail) begin
      step_d   = 4'd0;
      resend_d = 2'd0;
`ifdef WHEEL_DETECT_EN
      wheel_d  = 1'b0;
`endif
      if (retry_q == 8'(MAX_RETRIES)) state_d = ERROR;
      else begin
        retry_d = retry_q + 8'd1;
        state_d = SEND;
      end
    end
    tmo_d = (state_d != state_q) ? '0 : tmo_q + TW'(1);
  end

  // Stream-mode framing: byte 1 must carry the always-one bit 3 to start a packet.
  always_comb begin
    idx_d       = idx_q;
    gap_d       = gap_q;
    hdr_d       = hdr_q;
    b1_d        = b1_q;
    sync_d      = 1'b0;
    pkt_valid_d = 1'b0;
    buttons_d   = buttons_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    ovf_d       = ovf_q;
`ifdef WHEEL_DETECT_EN
    b2_d        = b2_q;
    dz_d        = dz_q;
    last_idx    = wheel_q ? 2'd3 : 2'd2;
`else
    last_idx    = 2'd2;
`endif
    if (state_q == STREAM) begin
      if (rx_valid) begin
        gap_d = '0;
        if (idx_q == 2'd0 && !rx_data[3]) begin
          sync_d = 1'b1;
        end else if (idx_q == last_idx) begin
          idx_d       = 2'd0;
          pkt_valid_d = 1'b1;
          buttons_d   = hdr_q[2:0];
          ovf_d       = hdr_q[6:5];
          dx_d        = {hdr_q[3], b1_q};
`ifdef WHEEL_DETECT_EN
          if (wheel_q) begin
            dy_d = {hdr_q[4], b2_q};
            dz_d = rx_data[3:0];
          end else begin
            dy_d = {hdr_q[4], rx_data};
            dz_d = 4'd0;
          end
`else
          dy_d = {hdr_q[4], rx_data};
`endif
        end else begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd0) hdr_d = {rx_data[7:4], rx_data[2:0]};
          if (idx_q == 2'd1) b1_d = rx_data;
`ifdef WHEEL_DETECT_EN
          if (idx_q == 2'd2) b2_d = rx_data;
`endif
        end
      end else if (idx_q != 2'd0) begin
        if (gap_q == GAP_LAST) begin
          idx_d = 2'd0;
          gap_d = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_q     <= SEND;
      step_q      <= 4'd0;
      retry_q     <= 8'd0;
      resend_q    <= 2'd0;
      tmo_q       <= '0;
      tx_req_q    <= 1'b0;
      tx_data_q   <= 8'd0;
      idx_q       <= 2'd0;
      gap_q       <= '0;
      hdr_q       <= 7'd0;
      b1_q        <= 8'd0;
      pkt_valid_q <= 1'b0;
      sync_q      <= 1'b0;
      buttons_q   <= 3'd0;
      dx_q        <= 9'd0;
      dy_q        <= 9'd0;
      ovf_q       <= 2'd0;
`ifdef WHEEL_DETECT_EN
      wheel_q     <= 1'b0;
      b2_q        <= 8'd0;
      dz_q        <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      retry_q     <= retry_d;
      resend_q    <= resend_d;
      tmo_q       <= tmo_d;
      tx_req_q    <= tx_req_d;
      tx_data_q   <= tx_data_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      hdr_q       <= hdr_d;
      b1_q        <= b1_d;
      pkt_valid_q <= pkt_valid_d;
      sync_q      <= sync_d;
      buttons_q   <= buttons_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      ovf_q       <= ovf_d;
`ifdef WHEEL_DETECT_EN
      wheel_q     <= wheel_d;
      b2_q        <= b2_d;
      dz_q        <= dz_d;
`endif
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_req      = tx_req_q;
  assign init_done   = (state_q == STREAM);
  assign init_error  = (state_q == ERROR);
  assign pkt_valid   = pkt_valid_q;
  assign pkt_buttons = buttons_q;
  assign pkt_dx      = dx_q;
  assign pkt_dy      = dy_q;
  assign pkt_ovf     = ovf_q;
  assign sync_error  = sync_q;
`ifdef WHEEL_DETECT_EN
  assign pkt_dz        = dz_q;
  assign wheel_present = wheel_q;
`else
  assign pkt_dz        = 4'd0;
  assign wheel_present = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Bench for ps2_mouse_init_seq: plays both the byte transmitter and the mouse, then feeds packets.
// Packet expectations are computed arithmetically from the raw bytes sent.
`timescale 1ns/1ps
module tb_ps2_mouse_init_seq;
  localparam int TMO = 1000;
  localparam int GAP = 200;
  localparam int RETRIES = 3;
  localparam logic [7:0] RATE = 8'd100;

  logic clk = 1'b0, reset = 1'b1, restart = 1'b0;
  logic tx_ack = 1'b0, tx_err = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic [7:0] tx_data;
  logic tx_req, init_done, init_error, pkt_valid, wheel_present, sync_error;
  logic [2:0] pkt_buttons;
  logic [8:0] pkt_dx, pkt_dy;
  logic [1:0] pkt_ovf;
  logic [3:0] pkt_dz;

  int checks = 0, errors = 0;
  int pv_cnt = 0, se_cnt = 0;
  bit wheel_exp = 1'b0;

  always #5 clk = ~clk;

  ps2_mouse_init_seq #(
    .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP), .SAMPLE_RATE(RATE), .MAX_RETRIES(RETRIES)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .tx_data(tx_data), .tx_req(tx_req), .tx_ack(tx_ack), .tx_err(tx_err),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .init_done(init_done), .init_error(init_error),
    .pkt_valid(pkt_valid), .pkt_buttons(pkt_buttons), .pkt_dx(pkt_dx), .pkt_dy(pkt_dy),
    .pkt_ovf(pkt_ovf), .pkt_dz(pkt_dz), .wheel_present(wheel_present), .sync_error(sync_error)
  );

  always @(posedge clk) begin
    #1;
    if (pkt_valid === 1'b1) pv_cnt++;
    if (sync_error === 1'b1) se_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int raw, input int bits);
    return (raw >= (1 << (bits - 1))) ? raw - (1 << bits) : raw;
  endfunction

  task automatic tx_handshake(input bit use_err, output logic [7:0] b);
    int n = 0;
    while (tx_req !== 1'b1 && n < 4 * TMO) begin
      @(negedge clk);
      n++;
    end
    check("tx_req_raised", {31'd0, tx_req}, 32'd1);
    b = tx_data;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    if (use_err) tx_err = 1'b1; else tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    tx_err = 1'b0;
    check("tx_req_dropped", {31'd0, tx_req}, 32'd0);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_clears_done", {31'd0, init_done}, 32'd0);
    check("restart_clears_error", {31'd0, init_error}, 32'd0);
  endtask

  // Mouse answers every command correctly; optionally NAKs one command fe_n times.
  task automatic run_init(input int fe_at, input int fe_n);
    logic [7:0] cmds[$];
    logic [7:0] b;
    cmds = '{8'hFF, 8'hF3, RATE};
`ifdef WHEEL_DETECT_EN
    cmds.push_back(8'hF3); cmds.push_back(8'hC8);
    cmds.push_back(8'hF3); cmds.push_back(8'h64);
    cmds.push_back(8'hF3); cmds.push_back(8'h50);
    cmds.push_back(8'hF2);
`endif
    cmds.push_back(8'hF4);
    foreach (cmds[i]) begin
      tx_handshake(1'b0, b);
      check("cmd_byte", {24'd0, b}, {24'd0, cmds[i]});
      if (i == fe_at) begin
        for (int r = 0; r < fe_n; r++) begin
          rx_byte(8'hFE);
          tx_handshake(1'b0, b);
          check("resent_byte", {24'd0, b}, {24'd0, cmds[i]});
        end
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      rx_byte(8'hFA);
      if (i == 0) begin
        rx_byte(8'hAA);
        rx_byte(8'h00);
      end
      if (cmds[i] == 8'hF2) rx_byte(8'h03);
    end
    repeat (2) @(negedge clk);
`ifdef WHEEL_DETECT_EN
    wheel_exp = 1'b1;
`else
    wheel_exp = 1'b0;
`endif
    check("init_done", {31'd0, init_done}, 32'd1);
    check("init_error_low", {31'd0, init_error}, 32'd0);
    check("wheel_present", {31'd0, wheel_present}, {31'd0, wheel_exp});
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input int max_gap);
    logic [7:0] p[4];
    int plen, pv0, exp_dx, exp_dy, exp_dz;
    p = '{b0, b1, b2, b3};
    plen = wheel_exp ? 4 : 3;
    pv0 = pv_cnt;
    for (int i = 0; i < plen; i++) begin
      if (i > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      rx_byte(p[i]);
    end
    exp_dx = int'(b1) - ((int'(b0) / 16) % 2) * 256;
    exp_dy = int'(b2) - ((int'(b0) / 32) % 2) * 256;
    exp_dz = wheel_exp ? sx(int'(b3) % 16, 4) : 0;
    check("pkt_valid_pulse", {31'd0, pkt_valid}, 32'd1);
    check("pkt_buttons", {29'd0, pkt_buttons}, int'(b0) % 8);
    check("pkt_ovf", {30'd0, pkt_ovf}, int'(b0) / 64);
    check("pkt_dx", 32'($signed(pkt_dx)), exp_dx);
    check("pkt_dy", 32'($signed(pkt_dy)), exp_dy);
    check("pkt_dz", 32'($signed(pkt_dz)), exp_dz);
    repeat (3) @(negedge clk);
    check("pkt_valid_once", pv_cnt - pv0, 32'd1);
    check("pkt_dx_held", 32'($signed(pkt_dx)), exp_dx);
  endtask

  initial begin
    logic [7:0] b;
    int n, fails, pv0, se0;
    int kinds[4];

    repeat (3) @(negedge clk);
    check("rst_tx_req", {31'd0, tx_req}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_init_error", {31'd0, init_error}, 32'd0);
    check("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
    check("rst_sync_error", {31'd0, sync_error}, 32'd0);
    check("rst_wheel", {31'd0, wheel_present}, 32'd0);
    check("rst_pkt_dx", {23'd0, pkt_dx}, 32'd0);
    check("rst_pkt_dz", {28'd0, pkt_dz}, 32'd0);
    reset = 1'b0;

    run_init(-1, 0);
    $display("clean init complete");

    send_pkt(8'h19, 8'h05, 8'hF0, 8'h00, 4);
    $display("packet 19 05 F0: dx=%0d dy=%0d", $signed(pkt_dx), $signed(pkt_dy));
`ifdef WHEEL_DETECT_EN
    send_pkt(8'h08, 8'h00, 8'h00, 8'h0F, 2);
    $display("wheel packet: dz=%0d", $signed(pkt_dz));
`endif

    // Realignment: bad first byte, then a partial packet abandoned by an idle gap.
    pv0 = pv_cnt;
    se0 = se_cnt;
    rx_byte(8'h05);
    check("sync_error_pulse", {31'd0, sync_error}, 32'd1);
    rx_byte(8'h08);
    rx_byte(8'h01);
    repeat (GAP + 1) @(negedge clk);
    send_pkt(8'h08, 8'h02, 8'h03, 8'h00, 0);
    check("realign_sync_count", se_cnt - se0, 32'd1);
    check("realign_pkt_count", pv_cnt - pv0, 32'd1);
    $display("realign: dx=%0d dy=%0d", $signed(pkt_dx), $signed(pkt_dy));

    for (int k = 0; k < 20; k++) begin
      se0 = se_cnt;
      n = ($urandom_range(0, 3) == 0) ? 1 : 0;
      if (n == 1) rx_byte(8'($urandom) & 8'hF7);
      send_pkt(8'($urandom) | 8'h08, 8'($urandom), 8'($urandom), 8'($urandom), GAP - 1);
      check("rand_sync_count", se_cnt - se0, n);
      $display("random packet %0d: dx=%0d dy=%0d junk=%0d", k, $signed(pkt_dx), $signed(pkt_dy), n);
    end

    pulse_restart();
    run_init(1, 1);
    $display("init with one resend of F3 complete");

    // Four failures in a row: timeout (after two tolerated resends), third resend, tx_err, timeout.
    pulse_restart();
    kinds = '{0, 1, 2, 0};
    fails = 0;
    foreach (kinds[a]) begin
      tx_handshake(kinds[a] == 2, b);
      check("retry_cmd", {24'd0, b}, 32'h0000_00FF);
      if (kinds[a] == 0 && a == 0) begin
        for (int r = 0; r < 2; r++) begin
          rx_byte(8'hFE);
          tx_handshake(1'b0, b);
          check("resend_ff", {24'd0, b}, 32'h0000_00FF);
        end
      end
      if (kinds[a] == 1) begin
        for (int r = 0; r < 2; r++) begin
          rx_byte(8'hFE);
          tx_handshake(1'b0, b);
          check("resend_ff", {24'd0, b}, 32'h0000_00FF);
        end
        rx_byte(8'hFE);
      end
      fails++;
      if (fails <= RETRIES) begin
        if (kinds[a] == 0) begin
          n = 1;
          while (tx_req !== 1'b1 && n < 3 * TMO) begin
            @(negedge clk);
            if (tx_req !== 1'b1) n++;
          end
          // TMO cycles waiting for the response, plus one cycle to relaunch the command.
          check("timeout_gap", n, TMO + 1);
        end
        $display("failure %0d handled, command relaunched", fails);
      end else begin
        n = 0;
        while (init_error !== 1'b1 && tx_req !== 1'b1 && n < 3 * TMO) begin
          @(negedge clk);
          n++;
        end
        repeat (20) @(negedge clk);
        check("error_state", {31'd0, init_error}, 32'd1);
        check("error_tx_idle", {31'd0, tx_req}, 32'd0);
        check("error_not_done", {31'd0, init_done}, 32'd0);
        $display("failure %0d: init_error=%0b", fails, init_error);
      end
    end

    pulse_restart();
    run_init(-1, 0);
    send_pkt(8'h28, 8'h80, 8'h7F, 8'h01, 3);
    $display("recovered after restart: dx=%0d dy=%0d", $signed(pkt_dx), $signed(pkt_dy));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
